// File: rtl/dsp_muladd_pkg.sv
// dsp_muladd_pkg: shared widths and depths for the DSP48E2 mul-add issue front end.
package dsp_muladd_pkg;
    localparam int W          = 8;
    localparam int LAT        = 3;
    localparam int C_DELAY    = LAT - 1;
    localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/dsp_muladd_skid.sv
// dsp_muladd_skid: 2-entry result FIFO absorbing the DSP output while the consumer stalls.
module dsp_muladd_skid
    import dsp_muladd_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   cnt
);
    logic [W-1:0] mem [SKID_DEPTH];
    logic         wr;
    logic         rd;

    assign dout = mem[rd];

    // A push onto a full FIFO only happens alongside a pop, so writing the slot being read is safe.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem <= '{default: '0};
            wr  <= 1'b0;
            rd  <= 1'b0;
            cnt <= '0;
        end else begin
            if (push) begin
                mem[wr] <= din;
                wr      <= ~wr;
            end
            if (pop)
                rd <= ~rd;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/dsp_muladd_issue.sv
// dsp_muladd_issue: valid/ready issue front end driving the DSP48E2 (a*b+c) pipeline.
// Define DSP_MUXADD_SKID_EN to insert a 2-entry skid buffer on the result path.
module dsp_muladd_issue
    import dsp_muladd_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [W-1:0] in_c,
    output logic [W-1:0] dsp_a,
    output logic [W-1:0] dsp_b,
    output logic [W-1:0] dsp_c,
    output logic         dsp_en,
    input  logic [W-1:0] dsp_y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_y,
    output logic         busy
);
    logic [LAT-1:0] vld;
    logic [W-1:0]   c_d1;
    logic [W-1:0]   c_d2;
    logic           accept;

    assign dsp_a    = in_a;
    assign dsp_b    = in_b;
    assign dsp_c    = c_d2;
    assign in_ready = dsp_en & ~reset;
    assign accept   = in_valid & in_ready;

    // c skips the A/B register and the multiplier stage, so it trails by two en-cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld  <= '0;
            c_d1 <= '0;
            c_d2 <= '0;
        end else if (dsp_en) begin
            vld  <= {vld[LAT-2:0], accept};
            c_d1 <= in_c;
            c_d2 <= c_d1;
        end
    end

`ifdef DSP_MUXADD_SKID_EN
    logic [1:0] cnt;

    assign dsp_en    = (cnt != 2'(SKID_DEPTH)) | out_ready;
    assign out_valid = cnt != 2'd0;
    assign busy      = |vld | out_valid;

    dsp_muladd_skid u_skid (
        .clock (clock),
        .reset (reset),
        .push  (vld[LAT-1] & dsp_en),
        .pop   (out_valid & out_ready),
        .din   (dsp_y),
        .dout  (out_y),
        .cnt   (cnt)
    );
`else
    assign dsp_en    = ~vld[LAT-1] | out_ready;
    assign out_valid = vld[LAT-1];
    assign out_y     = dsp_y;
    assign busy      = |vld;
`endif
endmodule
